mem_fill_verify_master: RTL and testbench

MEM_FILL_VERIFY_MASTER -- requirements
Module: mem_fill_verify_master

---
 rtl/mem_fill_verify_master.sv | 184 ++++++++++++++++++
 tb/tb_mem_fill_verify_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_verify_master.sv
// Avalon-MM memory fill/verify master: writes seed+i to base+i (mod DEPTH), reads back and compares.
// Optional first-miscompare capture ports are enabled by defining MEM_FILL_VERIFY_ERRCAP_EN.
module mem_fill_verify_master #(
  parameter int ADDR_W       = 14,
  parameter int DEPTH        = 10240,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       first_err_data,
`endif
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q, addr_q;
  logic [ADDR_W:0]     len_q, cnt_q;
  logic [31:0]         seed_q, data_q;
  logic [2:0]          drain_cnt;
  logic                pipe_vld  [READ_LATENCY];
  logic [31:0]         pipe_exp  [READ_LATENCY];
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
  logic [ADDR_W-1:0]   pipe_addr [READ_LATENCY];
`endif
  logic                start_go, abort_go, last_beat, miscmp;
  logic [15:0]         err_nxt;
  logic [ADDR_W-1:0]   addr_inc;

  assign start_go  = (state == IDLE) && start && !abort;
  assign abort_go  = (state != IDLE) && abort;
  assign last_beat = (cnt_q == len_q - (ADDR_W+1)'(1));
  assign addr_inc  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign miscmp    = pipe_vld[READ_LATENCY-1] && (avm_readdata != pipe_exp[READ_LATENCY-1]);
  assign err_nxt   = (miscmp && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

  always_comb begin
    state_nxt      = state;
    busy           = (state != IDLE);
    done           = 1'b0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_byteenable = '0;
    avm_address    = '0;
    avm_writedata  = '0;
    case (state)
      IDLE: begin
        // An empty run still spends READ_LATENCY cycles in DRAIN so the
        // start-to-done latency stays 2L+READ_LATENCY+1 for every L.
        if (start_go) state_nxt = (length == '0) ? DRAIN : WRITE;
      end
      WRITE: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_byteenable = 4'hF;
        avm_address    = addr_q;
        avm_writedata  = data_q;
        if (last_beat) state_nxt = READ;
      end
      READ: begin
        avm_chipselect = 1'b1;
        avm_byteenable = 4'hF;
        avm_address    = addr_q;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 3'(READ_LATENCY - 1)) state_nxt = DONE;
      end
      DONE: begin
        done      = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_go) begin
      state_nxt      = IDLE;
      avm_chipselect = 1'b0;
      avm_write      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      data_q    <= '0;
      drain_cnt <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_exp[i] <= '0;
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
        pipe_addr[i] <= '0;
`endif
      end
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
      first_err_addr <= '0;
      first_err_data <= '0;
`endif
    end else begin
      state     <= state_nxt;
      err_count <= err_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;

      // Expected data and issue address ride alongside the read latency.
      pipe_vld[0] <= (state == READ) && !abort_go;
      pipe_exp[0] <= data_q;
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
      pipe_addr[0] <= addr_q;
`endif
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1] && !abort_go;
        pipe_exp[i] <= pipe_exp[i-1];
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
        pipe_addr[i] <= pipe_addr[i-1];
`endif
      end

`ifdef MEM_FILL_VERIFY_ERRCAP_EN
      if (miscmp && err_count == '0) begin
        first_err_addr <= pipe_addr[READ_LATENCY-1];
        first_err_data <= avm_readdata;
      end
`endif

      if (state == WRITE || state == READ) begin
        if (last_beat) begin
          addr_q <= base_q;
          data_q <= seed_q;
          cnt_q  <= '0;
        end else begin
          addr_q <= addr_inc;
          data_q <= data_q + 32'd1;
          cnt_q  <= cnt_q + (ADDR_W+1)'(1);
        end
      end

      if (state == DRAIN && state_nxt == DONE) pass <= (err_nxt == '0);

      if (start_go) begin
        base_q    <= base_addr;
        addr_q    <= base_addr;
        len_q     <= length;
        cnt_q     <= '0;
        seed_q    <= seed;
        data_q    <= seed;
        pass      <= 1'b0;
        err_count <= '0;
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
        first_err_addr <= '0;
        first_err_data <= '0;
`endif
      end

      if (abort_go) begin
        pass <= 1'b0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_vld[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_fill_verify_master.sv
// Directed self-checking bench for mem_fill_verify_master with a 1-cycle-latency memory model.
module tb_mem_fill_verify_master;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 10240;

  logic              clk = 1'b0;
  logic              reset_n, start, abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [31:0]       seed;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect, avm_write;
  logic [31:0]       avm_writedata, avm_readdata;
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
  logic [ADDR_W-1:0] first_err_addr;
  logic [31:0]       first_err_data;
`endif

  mem_fill_verify_master #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
`endif
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  // Memory model plus bus monitor.
  logic [31:0] mem [DEPTH];
  logic        corrupt5 = 1'b0;
  int          cs_cnt = 0;
  logic        be_bad = 1'b0;
  int          wr_addr_q[$], rd_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(posedge clk) begin
    if (avm_chipselect) begin
      cs_cnt++;
      if (avm_write) begin
        mem[avm_address] <= (corrupt5 && avm_address == 14'd5) ? 32'hDEAD : avm_writedata;
        wr_addr_q.push_back(int'(avm_address));
        wr_data_q.push_back(avm_writedata);
        if (avm_byteenable != 4'hF) be_bad = 1'b1;
      end else begin
        avm_readdata <= mem[avm_address];
        rd_addr_q.push_back(int'(avm_address));
      end
    end
  end

  int n_checks = 0, n_pass = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic clear_mon();
    cs_cnt = 0; be_bad = 1'b0;
    wr_addr_q.delete(); rd_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l, input logic [31:0] s);
    @(posedge clk); #1;
    clear_mon();
    base_addr = b; length = l; seed = s; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 300; k++) begin
      if (done) begin dc = cyc; break; end
      step();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pass"}, pass, 0);
    check_eq({tag, "_err"}, err_count, 0);
    check_eq({tag, "_cs"}, avm_chipselect, 0);
    check_eq({tag, "_wr"}, avm_write, 0);
    check_eq({tag, "_addr"}, avm_address, 0);
    check_eq({tag, "_wdata"}, avm_writedata, 0);
    check_eq({tag, "_be"}, avm_byteenable, 0);
  endtask

  int   dc;
  logic saw_done;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0; seed = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // Ideal fill/verify, L=16.
    pulse_start(14'd0, 15'd16, 32'h1000);
    wait_done(dc);
    check_eq("a_done_cycle", dc, 34);
    check_eq("a_pass", pass, 1);
    check_eq("a_err", err_count, 0);
    check_eq("a_nwr", wr_data_q.size(), 16);
    check_eq("a_wdata0", (wr_data_q.size() > 0) ? wr_data_q[0] : 0, 32'h1000);
    check_eq("a_wdata15", (wr_data_q.size() > 15) ? wr_data_q[15] : 0, 32'h100F);
    check_eq("a_be", be_bad, 0);
    check_eq("a_nrd", rd_addr_q.size(), 16);
    step();
    check_eq("a_busy_after", busy, 0);
    check_eq("a_pass_hold", pass, 1);

    // Word 5 corrupted by the memory.
    corrupt5 = 1'b1;
    pulse_start(14'd0, 15'd16, 32'h1000);
    wait_done(dc);
    corrupt5 = 1'b0;
    check_eq("b_done_cycle", dc, 34);
    check_eq("b_pass", pass, 0);
    check_eq("b_err", err_count, 1);
`ifdef MEM_FILL_VERIFY_ERRCAP_EN
    check_eq("b_first_addr", first_err_addr, 5);
    check_eq("b_first_data", first_err_data, 32'hDEAD);
`endif
    step();
    check_eq("b_err_hold", err_count, 1);

    // Zero-length run.
    pulse_start(14'd0, 15'd0, 32'h55);
    wait_done(dc);
    check_eq("c_done_cycle", dc, 2);
    check_eq("c_pass", pass, 1);
    check_eq("c_err", err_count, 0);
    check_eq("c_cs", cs_cnt, 0);
    step();

    // Address wrap at DEPTH.
    pulse_start(14'd10238, 15'd4, 32'hA0);
    wait_done(dc);
    check_eq("d_done_cycle", dc, 10);
    check_eq("d_pass", pass, 1);
    check_eq("d_nwr", wr_addr_q.size(), 4);
    check_eq("d_nrd", rd_addr_q.size(), 4);
    if (wr_addr_q.size() == 4 && rd_addr_q.size() == 4) begin
      check_eq("d_wa0", wr_addr_q[0], 10238);
      check_eq("d_wa1", wr_addr_q[1], 10239);
      check_eq("d_wa2", wr_addr_q[2], 0);
      check_eq("d_wa3", wr_addr_q[3], 1);
      check_eq("d_ra0", rd_addr_q[0], 10238);
      check_eq("d_ra1", rd_addr_q[1], 10239);
      check_eq("d_ra2", rd_addr_q[2], 0);
      check_eq("d_ra3", rd_addr_q[3], 1);
    end
    step();

    // Abort in the third READ cycle (cycle 19).
    pulse_start(14'd0, 15'd16, 32'h2000);
    while (cyc < 19) step();
    check_eq("e_in_read", {avm_chipselect, avm_write}, 2'b10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("e_busy", busy, 0);
    check_eq("e_cs", avm_chipselect, 0);
    check_eq("e_pass", pass, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    check_eq("e_no_done", saw_done, 0);
    check_eq("e_pass_hold", pass, 0);
    pulse_start(14'd0, 15'd16, 32'h3000);
    wait_done(dc);
    check_eq("e2_done_cycle", dc, 34);
    check_eq("e2_pass", pass, 1);
    step();

    // Start + abort together in IDLE: no run.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_eq("f_busy", busy, 0);

    // Reset during WRITE, then a fresh run.
    pulse_start(14'd0, 15'd16, 32'h4000);
    while (cyc < 5) step();
    check_eq("g_busy_pre", busy, 1);
    reset_n = 1'b0;
    step();
    check_idle_outputs("g_rst");
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    check_eq("g_no_done", saw_done, 0);
    pulse_start(14'd0, 15'd16, 32'h4000);
    wait_done(dc);
    check_eq("g2_done_cycle", dc, 34);
    check_eq("g2_pass", pass, 1);
    check_eq("g2_err", err_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
